// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode-side read, writeback, scoreboard mark and status signals of regfile_sb.
interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              rd_busy1, rd_busy2;
  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  logic              any_busy;
  logic              wr_hazard;
  modport master (
    output rd_addr1, rd_addr2, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, mark_en, mark_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, any_busy, wr_hazard
  );
  modport slave (
    input  rd_addr1, rd_addr2, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, mark_en, mark_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, any_busy, wr_hazard
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/2-write register file with a per-register load busy scoreboard.
// Define REGFILE_BYPASS_EN for write-through forwarding on the read ports.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy, busy_n;
  logic              wa_e, wb_e, mark_e, hazard;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return (!rst_n || is_zero(a)) ? '0 :
           (wa_e && bus.wa_addr == a) ? bus.wa_data :
           (wb_e && bus.wb_addr == a) ? bus.wb_data : regs[a];
`else
    return (!rst_n || is_zero(a)) ? '0 : regs[a];
`endif
  endfunction

  function automatic logic rb(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return (!rst_n || is_zero(a)) ? 1'b0 :
           (wb_e && bus.wb_addr == a && !(mark_e && bus.mark_addr == a)) ? 1'b0 : busy[a];
`else
    return (!rst_n || is_zero(a)) ? 1'b0 : busy[a];
`endif
  endfunction

  // Register 0 traffic is masked here so it neither writes, marks nor raises a hazard.
  always_comb begin
    wa_e   = bus.wa_en && !is_zero(bus.wa_addr);
    wb_e   = bus.wb_en && !is_zero(bus.wb_addr);
    mark_e = bus.mark_en && !is_zero(bus.mark_addr);
    busy_n = busy;
    if (wb_e) busy_n[bus.wb_addr] = 1'b0;
    if (mark_e) busy_n[bus.mark_addr] = 1'b1;
    hazard = (wa_e && wb_e && bus.wa_addr == bus.wb_addr) ||
             (wa_e && busy[bus.wa_addr]) ||
             (wb_e && !busy[bus.wb_addr]) ||
             (mark_e && busy[bus.mark_addr]);
    bus.rd_data1 = rd(bus.rd_addr1);
    bus.rd_data2 = rd(bus.rd_addr2);
    bus.rd_busy1 = rb(bus.rd_addr1);
    bus.rd_busy2 = rb(bus.rd_addr2);
  end

  // Port A is written last so it wins an address collision with port B.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs          <= '{default: '0};
      busy          <= '0;
      bus.any_busy  <= 1'b0;
      bus.wr_hazard <= 1'b0;
    end else begin
      if (wb_e) regs[bus.wb_addr] <= bus.wb_data;
      if (wa_e) regs[bus.wa_addr] <= bus.wa_data;
      busy          <= busy_n;
      bus.any_busy  <= |busy_n;
      bus.wr_hazard <= hazard;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed stimulus with queued expectations checked by a negedge monitor.
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int RD1 = 0, RD2 = 1, BSY1 = 2, BSY2 = 3, ANY = 4, HAZ = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] want;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [15:0] act(input int sel);
    return sel == RD1  ? bus.rd_data1 :
           sel == RD2  ? bus.rd_data2 :
           sel == BSY1 ? {15'd0, bus.rd_busy1} :
           sel == BSY2 ? {15'd0, bus.rd_busy2} :
           sel == ANY  ? {15'd0, bus.any_busy} : {15'd0, bus.wr_hazard};
  endfunction

  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (act(e.sel) !== e.want) begin
        fails++;
        $display("FAIL %s: got 0x%04h, expected 0x%04h", e.name, act(e.sel), e.want);
      end
    end

  task automatic chk(input string name, input int sel, input logic [15:0] want);
    q.push_back('{name, sel, want});
  endtask

  task automatic step(input logic a_en, input logic [3:0] a_ad, input logic [15:0] a_d,
                      input logic b_en, input logic [3:0] b_ad, input logic [15:0] b_d,
                      input logic m_en, input logic [3:0] m_ad,
                      input logic [3:0] r1, input logic [3:0] r2);
    @(posedge clk);
    #1;
    bus.wa_en = a_en; bus.wa_addr = a_ad; bus.wa_data = a_d;
    bus.wb_en = b_en; bus.wb_addr = b_ad; bus.wb_data = b_d;
    bus.mark_en = m_en; bus.mark_addr = m_ad;
    bus.rd_addr1 = r1; bus.rd_addr2 = r2;
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0); rst_n = 1'b1;
    chk("reset_rd", RD1, 16'h0); chk("reset_busy", BSY1, 16'h0);
    chk("reset_any", ANY, 16'h0); chk("reset_haz", HAZ, 16'h0);
    step(1, 5, 16'hBEEF, 0, 0, 0, 1, 5, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("r5_write", RD1, 16'hBEEF); chk("r5_busy", BSY1, 16'h1);
    chk("r5_any", ANY, 16'h1); chk("r5_haz", HAZ, 16'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0); rst_n = 1'b0;
    chk("async_rst_rd", RD1, 16'h0); chk("async_rst_busy", BSY1, 16'h0);
    chk("async_rst_any", ANY, 16'h0); chk("async_rst_haz", HAZ, 16'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); rst_n = 1'b1;
    step(1, 3, 16'h1234, 1, 7, 16'hABCD, 0, 0, 3, 7);
    chk("dual_pre_haz", HAZ, 16'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3, 7);
    chk("dual_r3", RD1, 16'h1234); chk("dual_r7", RD2, 16'hABCD);
    chk("dual_b_unmarked_haz", HAZ, 16'h1);
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    chk("haz_one_cycle", HAZ, 16'h0);
    step(1, 4, 16'h1111, 1, 4, 16'h2222, 0, 0, 4, 0);
    chk("r4_marked", BSY1, BYP ? 16'h0 : 16'h1); chk("r4_any", ANY, 16'h1); chk("r4_pre_haz", HAZ, 16'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    chk("collide_a_wins", RD1, 16'h1111); chk("collide_busy", BSY1, 16'h0);
    chk("collide_haz", HAZ, 16'h1); chk("collide_any", ANY, 16'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    chk("collide_haz_end", HAZ, 16'h0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 1, 9, 16'h00FF, 1, 9, 9, 0);
    chk("r9_busy", BSY1, 16'h1); chk("r9_any", ANY, 16'h1); chk("r9_mark_haz", HAZ, 16'h0);
    step(0, 0, 0, 1, 9, 16'h0A0A, 0, 0, 9, 0);
    chk("r9_b_data", RD1, BYP ? 16'h0A0A : 16'h00FF); chk("r9_mark_wins", BSY1, BYP ? 16'h0 : 16'h1);
    chk("r9_any_hold", ANY, 16'h1); chk("r9_remark_haz", HAZ, 16'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("r9_b_data2", RD1, 16'h0A0A); chk("r9_clear", BSY1, 16'h0);
    chk("r9_any_clear", ANY, 16'h0); chk("r9_clear_haz", HAZ, 16'h0);
    step(1, 0, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_data", RD1, 16'h0); chk("r0_busy", BSY1, 16'h0);
    chk("r0_any", ANY, 16'h0); chk("r0_haz", HAZ, 16'h0);
    step(1, 2, 16'h5A5A, 0, 0, 0, 0, 0, 2, 0);
    chk("bypass_same_cycle", RD1, BYP ? 16'h5A5A : 16'h0000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    chk("r2_next_cycle", RD1, 16'h5A5A); chk("r2_haz", HAZ, 16'h0);
    step(0, 0, 0, 0, 0, 0, 1, 6, 0, 6);
    step(1, 6, 16'h7777, 0, 0, 0, 0, 0, 0, 6);
    chk("r6_busy", BSY2, 16'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    chk("waw_data", RD2, 16'h7777); chk("waw_keeps_busy", BSY2, 16'h1); chk("waw_haz", HAZ, 16'h1);
    step(0, 0, 0, 1, 6, 16'h8888, 0, 0, 0, 6);
    chk("waw_haz_end", HAZ, 16'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    chk("r6_load", RD2, 16'h8888); chk("r6_clear", BSY2, 16'h0);
    chk("r6_any", ANY, 16'h0); chk("r6_haz", HAZ, 16'h0);
    step(1, 15, 16'hC3C3, 1, 14, 16'h3C3C, 1, 14, 15, 14);
    step(0, 0, 0, 0, 0, 0, 0, 0, 15, 14);
    chk("r15_top", RD1, 16'hC3C3); chk("r14_data", RD2, 16'h3C3C);
    chk("r14_mark_over_clear", BSY2, 16'h1); chk("r14_haz", HAZ, 16'h1);
    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with two write ports and a per-register busy scoreboard, the next generation of the CPU's 16-entry register file. It serves the decode stage with two combinational read ports. Port A takes ALU writeback and port B takes load (memory) writeback. The scoreboard tracks registers with an outstanding load, so the hazard unit can stall on busy sources.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  read data, combinational
- rd_busy1, rd_busy2  out  1  busy bit of the addressed register, combinational
- wa_en  in  1  port A write enable (ALU writeback)
- wa_addr  in  ADDR_W  port A address
- wa_data  in  DATA_W  port A data
- wb_en  in  1  port B write enable (load writeback); also clears busy
- wb_addr  in  ADDR_W  port B address
- wb_data  in  DATA_W  port B data
- mark_en  in  1  set busy on mark_addr (load issued)
- mark_addr  in  ADDR_W  register to mark busy
- any_busy  out  1  OR of all busy bits, registered
- wr_hazard  out  1  registered one-cycle pulse: protocol violation detected last cycle

## Operation
- Storage: 2**ADDR_W words of DATA_W bits, plus 2**ADDR_W busy bits.
- Reset (rst_n low, asynchronous):
  - all registers are 0 and all busy bits are 0
  - any_busy = 0, wr_hazard = 0
  - reads during reset return 0 and not-busy
- Write, port A: on the clock edge, if wa_en, the register at wa_addr takes wa_data. The busy bit is unchanged.
- Write, port B: on the clock edge, if wb_en, the register at wb_addr takes wb_data and its busy bit clears.
- Both ports write the same address in one cycle: port A data wins. The busy bit still clears because wb_en is set. wr_hazard pulses.
- Mark: if mark_en, the busy bit of mark_addr sets.
  - Mark and port B clear on the same address in one cycle: mark wins (new load pending), and the data from port B is still written.
  - Mark on an already-busy register: stays busy, and wr_hazard pulses.
- Port A write to a register that is busy at the clock edge: the write happens and wr_hazard pulses (WAW against an outstanding load).
- Port B write to a register that is not busy: the write happens and wr_hazard pulses.
- Register 0 with ZERO_REG=1: writes and marks to it are silently dropped and raise no hazard. rd_data reads 0 and rd_busy reads 0.
- Addresses cover the full range, so there is no out-of-range case.
- wr_hazard is the registered OR of all hazard conditions in the cycle. It is informational only and never blocks a write.
- any_busy is registered from the next-state busy vector, so it is valid in the cycle after a mark or clear.

## Timing
- Read latency is 0 cycles (combinational from the address).
- Write latency: a write at edge N is visible on a non-bypassed read after edge N.
- A mark at edge N makes rd_busy high after edge N, and any_busy high after edge N.
- wr_hazard is high for exactly one cycle, the cycle after the offending edge.
- Reset takes effect immediately. Deassertion is sampled at the next rising edge; the first write can land on the edge after rst_n rises.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - A read whose address matches an enabled write in the same cycle returns that write's data, with port A taking priority over port B.
  - rd_busy reads 0 when wb_en clears that address in the same cycle, unless a simultaneous mark on that address re-sets it.
  - Register 0 is never bypassed when ZERO_REG=1.
- Undefined: reads return array contents only and rd_busy returns the stored bit. The decode stage must then tolerate a one-cycle write-to-read delay.

## Test plan
- Reset: write 0xBEEF to r5, then assert rst_n low mid-cycle -> rd_data for r5 reads 0x0000 immediately, and any_busy = 0.
- Dual write to different addresses: A writes r3=0x1234 and B writes r7=0xABCD in the same cycle -> the next cycle reads r3=0x1234 and r7=0xABCD, and wr_hazard = 0.
  - The r7 write has no prior mark, so wr_hazard = 1 in the following cycle.
- Collision: mark r4, then next cycle A writes r4=0x1111 and B writes r4=0x2222 together -> r4 reads 0x1111, rd_busy = 0, and wr_hazard = 1 for one cycle.
- Scoreboard sequence:
  - mark r9 -> rd_busy for r9 = 1 and any_busy = 1
  - next cycle, B writes r9=0x00FF together with a mark of r9 -> r9 = 0x00FF and stays busy
  - next cycle, B writes r9 again -> busy clears, and any_busy = 0 one cycle later
- Zero register: with ZERO_REG=1, A writes r0=0xFFFF and mark r0 -> r0 reads 0x0000, not busy, and wr_hazard = 0.
- Bypass:
  - With REGFILE_BYPASS_EN, A writes r2=0x5A5A while rd_addr1=2 -> rd_data1 = 0x5A5A in the same cycle.
  - Without the macro -> the old value in that cycle, then 0x5A5A in the next.
